drive_cmd_arbiter: RTL and testbench

Owns the motion/barrier inputs of the simulated car device and shares them between two requesters: the manual driving mode's 4-bit command and an autonomous command source. Sequences power-up and mode changes through a forced-stop handoff window. Sanitises contradictory commands, applies obstacle interlocks in auto mode, and stretches barrier requests into fixed-length pulses. Sits between the mode controllers and the UART car-simulation block at the top level.

---
 rtl/drive_cmd_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_drive_cmd_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_cmd_arbiter.sv
// drive_cmd_arbiter
// Shares the car's motion and barrier inputs between the manual driving mode
// and the autonomous command source. Every change of owner (including power-up)
// goes through a forced-stop handoff window before the new owner gets control.
// Contradictory command pairs are cancelled, auto mode honours the obstacle
// detectors, and single-cycle barrier requests are stretched into fixed pulses.
// Command bit order everywhere is {left, right, backward, forward} = [3:0].

module drive_cmd_arbiter #(
    parameter int HANDOFF_CYCLES       = 50_000_000,
    parameter int BARRIER_PULSE_CYCLES = 1_000_000,
    parameter int CNT_W                = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_now,
    input  logic       mode_sel,
    input  logic [3:0] man_cmd,
    input  logic [3:0] auto_cmd,
    input  logic       auto_valid,
    input  logic       auto_place_req,
    input  logic       auto_destroy_req,
    input  logic       front_detector,
    input  logic       back_detector,
    output logic       turn_left_signal,
    output logic       turn_right_signal,
    output logic       move_forward_signal,
    output logic       move_backward_signal,
    output logic       place_barrier_signal,
    output logic       destroy_barrier_signal,
    output logic [1:0] owner,
    output logic       auto_ready
);

    // The state encoding is visible on the owner port, so the values are fixed.
    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_MANUAL  = 2'b01,
        ST_HANDOFF = 2'b10,
        ST_AUTO    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] HANDOFF_RELOAD = CNT_W'(HANDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_RELOAD   = CNT_W'(BARRIER_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    // Registered state
    state_t           r_state;
    logic             r_target;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_pcnt;
    logic             r_place;
    logic             r_destroy;
    logic [3:0]       r_motion;
    logic             r_auto_ready;

    // Next-state values
    state_t           w_state_nxt;
    logic             w_target_nxt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_pcnt_nxt;
    logic             w_place_nxt;
    logic             w_destroy_nxt;
    logic [3:0]       w_motion_nxt;
    logic             w_auto_ready_nxt;

    // Cleaned-up command candidates
    logic             w_pulse_active;
    logic [3:0]       w_auto_cmd_eff;
    logic [3:0]       w_man_clean;
    logic [3:0]       w_auto_clean;

    // Cancel opposing pairs: left with right, backward with forward.
    function automatic logic [3:0] sanitise(input logic [3:0] cmd);
        logic [3:0] res;
        res = cmd;
        if (cmd[3] && cmd[2]) begin
            res[3:2] = 2'b00;
        end
        if (cmd[1] && cmd[0]) begin
            res[1:0] = 2'b00;
        end
        return res;
    endfunction

    // Obstacle interlock: never drive towards a detected obstacle; turning stays allowed.
    function automatic logic [3:0] interlock(input logic [3:0] cmd,
                                             input logic       front,
                                             input logic       back);
        logic [3:0] res;
        res = cmd;
        if (front) begin
            res[0] = 1'b0;
        end
        if (back) begin
            res[1] = 1'b0;
        end
        return res;
    endfunction

    assign w_pulse_active = r_place | r_destroy;
    assign w_auto_cmd_eff = auto_valid ? auto_cmd : 4'b0000;
    assign w_man_clean    = sanitise(man_cmd);
    assign w_auto_clean   = interlock(sanitise(w_auto_cmd_eff), front_detector, back_detector);

    // Next-state logic: ownership sequencing, handoff countdown, motion selection and barrier pulses.
    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_hcnt_nxt    = r_hcnt;
        w_pcnt_nxt    = '0;
        w_place_nxt   = 1'b0;
        w_destroy_nxt = 1'b0;
        w_motion_nxt  = 4'b0000;

        if (!power_now) begin
            w_state_nxt  = ST_OFF;
            w_target_nxt = 1'b0;
            w_hcnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt  = ST_HANDOFF;
                    w_target_nxt = mode_sel;
                    w_hcnt_nxt   = HANDOFF_RELOAD;
                end

                ST_HANDOFF: begin
                    // A late change of mind restarts the full stop window.
                    if (mode_sel != r_target) begin
                        w_target_nxt = mode_sel;
                        w_hcnt_nxt   = HANDOFF_RELOAD;
                    end else if (r_hcnt == '0) begin
                        w_state_nxt = r_target ? ST_AUTO : ST_MANUAL;
                    end else begin
                        w_hcnt_nxt = r_hcnt - CNT_ONE;
                    end
                end

                ST_MANUAL: begin
                    if (mode_sel) begin
                        w_state_nxt  = ST_HANDOFF;
                        w_target_nxt = 1'b1;
                        w_hcnt_nxt   = HANDOFF_RELOAD;
                    end else begin
                        w_motion_nxt = w_man_clean;
                    end
                end

                ST_AUTO: begin
                    if (!mode_sel) begin
                        // Leaving auto drops any barrier pulse in flight.
                        w_state_nxt  = ST_HANDOFF;
                        w_target_nxt = 1'b0;
                        w_hcnt_nxt   = HANDOFF_RELOAD;
                    end else begin
                        w_motion_nxt = w_auto_clean;
                        if (w_pulse_active) begin
                            // Requests during a pulse are dropped, not queued.
                            if (r_pcnt != '0) begin
                                w_place_nxt   = r_place;
                                w_destroy_nxt = r_destroy;
                                w_pcnt_nxt    = r_pcnt - CNT_ONE;
                            end
                        end else if (auto_place_req) begin
                            // Place wins over a simultaneous destroy request.
                            w_place_nxt = 1'b1;
                            w_pcnt_nxt  = PULSE_RELOAD;
                        end else if (auto_destroy_req) begin
                            w_destroy_nxt = 1'b1;
                            w_pcnt_nxt    = PULSE_RELOAD;
                        end
                    end
                end

                default: begin
                    w_state_nxt  = ST_OFF;
                    w_target_nxt = 1'b0;
                    w_hcnt_nxt   = '0;
                end
            endcase
        end

        w_auto_ready_nxt = (w_state_nxt == ST_AUTO) && !(w_place_nxt || w_destroy_nxt);
    end

    // State and output registers; reset forces the car to a safe, unpowered stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_OFF;
            r_target     <= 1'b0;
            r_hcnt       <= '0;
            r_pcnt       <= '0;
            r_place      <= 1'b0;
            r_destroy    <= 1'b0;
            r_motion     <= 4'b0000;
            r_auto_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_target     <= w_target_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_place      <= w_place_nxt;
            r_destroy    <= w_destroy_nxt;
            r_motion     <= w_motion_nxt;
            r_auto_ready <= w_auto_ready_nxt;
        end
    end

    assign owner                  = r_state;
    assign turn_left_signal       = r_motion[3];
    assign turn_right_signal      = r_motion[2];
    assign move_backward_signal   = r_motion[1];
    assign move_forward_signal    = r_motion[0];
    assign place_barrier_signal   = r_place;
    assign destroy_barrier_signal = r_destroy;
    assign auto_ready             = r_auto_ready;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Testbench for drive_cmd_arbiter with short handoff (4) and pulse (3) lengths.
// Expected output vectors {owner, auto_ready, place, destroy, left, right,
// backward, forward} are queued as stimulus is applied and popped as each
// clock edge produces the DUT's response.

module tb_drive_cmd_arbiter;

    localparam int HC = 4;
    localparam int PC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_now;
    logic       mode_sel;
    logic [3:0] man_cmd;
    logic [3:0] auto_cmd;
    logic       auto_valid;
    logic       auto_place_req;
    logic       auto_destroy_req;
    logic       front_detector;
    logic       back_detector;
    logic       turn_left_signal;
    logic       turn_right_signal;
    logic       move_forward_signal;
    logic       move_backward_signal;
    logic       place_barrier_signal;
    logic       destroy_barrier_signal;
    logic [1:0] owner;
    logic       auto_ready;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got;
    logic [8:0] expv;

    drive_cmd_arbiter #(
        .HANDOFF_CYCLES      (HC),
        .BARRIER_PULSE_CYCLES(PC),
        .CNT_W               (27)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .power_now             (power_now),
        .mode_sel              (mode_sel),
        .man_cmd               (man_cmd),
        .auto_cmd              (auto_cmd),
        .auto_valid            (auto_valid),
        .auto_place_req        (auto_place_req),
        .auto_destroy_req      (auto_destroy_req),
        .front_detector        (front_detector),
        .back_detector         (back_detector),
        .turn_left_signal      (turn_left_signal),
        .turn_right_signal     (turn_right_signal),
        .move_forward_signal   (move_forward_signal),
        .move_backward_signal  (move_backward_signal),
        .place_barrier_signal  (place_barrier_signal),
        .destroy_barrier_signal(destroy_barrier_signal),
        .owner                 (owner),
        .auto_ready            (auto_ready)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {owner, auto_ready, place_barrier_signal, destroy_barrier_signal,
                turn_left_signal, turn_right_signal, move_backward_signal, move_forward_signal};
    endfunction

    function automatic logic [8:0] ev(input logic [1:0] own, input logic rdy,
                                      input logic pl, input logic de, input logic [3:0] mot);
        return {own, rdy, pl, de, mot};
    endfunction

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; power_now = 1'b0; mode_sel = 1'b0; man_cmd = 4'b0; auto_cmd = 4'b0;
        auto_valid = 1'b0; auto_place_req = 1'b0; auto_destroy_req = 1'b0;
        front_detector = 1'b0; back_detector = 1'b0;
        #1 rst = 1'b0;
        #1 got = obs();
        checks++;
        if (got !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected %b", got, 9'b0);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ev(2'b00, 0, 0, 0, 4'b0000));
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL off_idle[%0d]: got %b expected %b", i, got, expv);
            end
        end
    endtask

    task automatic test_power_up_manual();
        power_now = 1'b1; mode_sel = 1'b0; man_cmd = 4'b0001;
        for (int i = 0; i < HC; i++) exp_q.push_back(ev(2'b10, 0, 0, 0, 4'b0000));
        exp_q.push_back(ev(2'b01, 0, 0, 0, 4'b0000));
        exp_q.push_back(ev(2'b01, 0, 0, 0, 4'b0001));
        for (int i = 0; i < HC + 2; i++) begin
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL power_up_manual[%0d]: got %b expected %b", i, got, expv);
            end
        end
    endtask

    task automatic test_sanitise();
        logic [3:0] cmds [6];
        logic [3:0] exps [6];
        cmds = '{4'b1101, 4'b0011, 4'b0110, 4'b1111, 4'b1000, 4'b1110};
        exps = '{4'b0001, 4'b0000, 4'b0110, 4'b0000, 4'b1000, 4'b0010};
        // Barrier requests in manual mode must be ignored
        auto_place_req = 1'b1; auto_destroy_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            man_cmd = cmds[i];
            exp_q.push_back(ev(2'b01, 0, 0, 0, exps[i]));
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL sanitise[%b]: got %b expected %b", cmds[i], got, expv);
            end
        end
        auto_place_req = 1'b0; auto_destroy_req = 1'b0;
    endtask

    task automatic test_reset_midrun();
        man_cmd = 4'b0001;
        exp_q.push_back(ev(2'b01, 0, 0, 0, 4'b0001));
        tick();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL midrun_forward: got %b expected %b", got, expv);
        end
        #2 rst = 1'b0;
        #1 got = obs();
        checks++;
        if (got !== 9'b0) begin
            errors++;
            $display("[TB] FAIL midrun_async_reset: got %b expected %b", got, 9'b0);
        end
        power_now = 1'b0; man_cmd = 4'b0000;
        #2 rst = 1'b1;
        exp_q.push_back(ev(2'b00, 0, 0, 0, 4'b0000));
        tick();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL after_reset_off: got %b expected %b", got, expv);
        end
    endtask

    task automatic test_handoff_retarget();
        logic       vals [8];
        logic [3:0] cmds [8];
        logic       frnt [8];
        logic       bck  [8];
        logic [3:0] exps [8];
        power_now = 1'b1; mode_sel = 1'b0;
        // Counter runs 3,2,1; toggle while it reads 1
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev(2'b10, 0, 0, 0, 4'b0000));
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL handoff_pre[%0d]: got %b expected %b", i, got, expv);
            end
        end
        mode_sel = 1'b1;
        for (int i = 0; i < HC + 1; i++) begin
            if (i < HC) exp_q.push_back(ev(2'b10, 0, 0, 0, 4'b0000));
            else        exp_q.push_back(ev(2'b11, 1, 0, 0, 4'b0000));
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL handoff_retarget[%0d]: got %b expected %b", i, got, expv);
            end
        end
        vals = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        cmds = '{4'b0001, 4'b0001, 4'b0010, 4'b1010, 4'b0101, 4'b1111, 4'b0001, 4'b0010};
        frnt = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bck  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exps = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            auto_valid = vals[i]; auto_cmd = cmds[i];
            front_detector = frnt[i]; back_detector = bck[i];
            exp_q.push_back(ev(2'b11, 1, 0, 0, exps[i]));
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL auto_cmd[%0d]: got %b expected %b", i, got, expv);
            end
        end
        auto_valid = 1'b0; auto_cmd = 4'b0000; front_detector = 1'b0; back_detector = 1'b0;
    endtask

    task automatic test_barrier();
        logic pl [6];
        logic de [6];
        // Same-cycle place+destroy, then a destroy attempt during pulse cycle 2
        pl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        de = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < PC; i++) exp_q.push_back(ev(2'b11, 0, 1, 0, 4'b0000));
        for (int i = 0; i < 3; i++)  exp_q.push_back(ev(2'b11, 1, 0, 0, 4'b0000));
        for (int i = 0; i < 6; i++) begin
            auto_place_req = pl[i]; auto_destroy_req = de[i];
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL barrier_place[%0d]: got %b expected %b", i, got, expv);
            end
        end
        // Destroy alone
        auto_place_req = 1'b0; auto_destroy_req = 1'b1;
        for (int i = 0; i < PC; i++) exp_q.push_back(ev(2'b11, 0, 0, 1, 4'b0000));
        exp_q.push_back(ev(2'b11, 1, 0, 0, 4'b0000));
        for (int i = 0; i < PC + 1; i++) begin
            tick();
            auto_destroy_req = 1'b0;
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL barrier_destroy[%0d]: got %b expected %b", i, got, expv);
            end
        end
    endtask

    task automatic test_power_off_abort();
        auto_place_req = 1'b1;
        exp_q.push_back(ev(2'b11, 0, 1, 0, 4'b0000));
        tick();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL abort_pulse_start: got %b expected %b", got, expv);
        end
        auto_place_req = 1'b0; power_now = 1'b0;
        exp_q.push_back(ev(2'b00, 0, 0, 0, 4'b0000));
        tick();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL abort_power_off: got %b expected %b", got, expv);
        end
        // Repower into auto; requests held through the handoff must be dropped
        power_now = 1'b1; mode_sel = 1'b1; auto_place_req = 1'b1;
        for (int i = 0; i < HC; i++) exp_q.push_back(ev(2'b10, 0, 0, 0, 4'b0000));
        exp_q.push_back(ev(2'b11, 1, 0, 0, 4'b0000));
        for (int i = 0; i < HC + 1; i++) begin
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL repower_auto[%0d]: got %b expected %b", i, got, expv);
            end
        end
        auto_place_req = 1'b0;
    endtask

    task automatic test_auto_to_manual();
        auto_place_req = 1'b1;
        exp_q.push_back(ev(2'b11, 0, 1, 0, 4'b0000));
        tick();
        got = obs(); expv = exp_q.pop_front(); checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL leave_auto_pulse: got %b expected %b", got, expv);
        end
        auto_place_req = 1'b0; mode_sel = 1'b0; man_cmd = 4'b0100;
        for (int i = 0; i < HC; i++) exp_q.push_back(ev(2'b10, 0, 0, 0, 4'b0000));
        exp_q.push_back(ev(2'b01, 0, 0, 0, 4'b0000));
        exp_q.push_back(ev(2'b01, 0, 0, 0, 4'b0100));
        for (int i = 0; i < HC + 2; i++) begin
            tick();
            got = obs(); expv = exp_q.pop_front(); checks++;
            if (got !== expv) begin
                errors++;
                $display("[TB] FAIL auto_to_manual[%0d]: got %b expected %b", i, got, expv);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_power_up_manual();
        test_sanitise();
        test_reset_midrun();
        test_handoff_retarget();
        test_barrier();
        test_power_off_abort();
        test_auto_to_manual();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
